inst_dispatcher: RTL and testbench

Sequencer between the AXI instruction receiver and the compute units. Pops instructions from the receiver's instruction output channel and routes each one to the execution unit named in its opcode field, using a valid/ready handshake. A round-robin arbiter merges the unit result streams back onto the receiver's single data/data_id/data_valid write port. Tracks outstanding work, so it can throttle issue and report busy.

---
 rtl/inst_dispatcher.sv | 176 +++++++++++++++++
 tb/tb_inst_dispatcher.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_dispatcher.sv
// inst_dispatcher: pops instructions from the AXI instruction receiver,
// issues each one to the execution unit named in its unit-select field, and
// merges the unit result streams back onto the receiver's single write port
// through a round-robin arbiter. It also counts work in flight for throttling
// and for the busy flag.
module inst_dispatcher #(
    parameter int DATA_WIDTH        = 64,
    parameter int INSTRUCTION_DEPTH = 16,
    parameter int NUM_UNITS         = 4,
    parameter int UNIT_FIELD_LSB    = 56,
    localparam int ID_W = $clog2(INSTRUCTION_DEPTH),
    localparam int UW   = $clog2(NUM_UNITS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_WIDTH-1:0]           instruction,
    input  logic [ID_W-1:0]                 instruction_id,
    input  logic                            instruction_valid,
    output logic                            instruction_next,
    input  logic                            halt,
    output logic [NUM_UNITS*DATA_WIDTH-1:0] unit_inst,
    output logic [NUM_UNITS*ID_W-1:0]       unit_id,
    output logic [NUM_UNITS-1:0]            unit_valid,
    input  logic [NUM_UNITS-1:0]            unit_ready,
    input  logic [NUM_UNITS*DATA_WIDTH-1:0] res_data,
    input  logic [NUM_UNITS*ID_W-1:0]       res_id,
    input  logic [NUM_UNITS-1:0]            res_valid,
    output logic [NUM_UNITS-1:0]            res_ready,
    output logic [DATA_WIDTH-1:0]           data,
    output logic [ID_W-1:0]                 data_id,
    output logic                            data_valid,
    output logic [ID_W:0]                   outstanding,
    output logic                            busy
);

    localparam logic [ID_W:0] MAX_OUT = (ID_W+1)'(INSTRUCTION_DEPTH);
    localparam logic [ID_W:0] CNT_ONE = (ID_W+1)'(1);
    localparam logic [UW-1:0] RR_ONE  = UW'(1);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                state, state_d;
    logic [DATA_WIDTH-1:0] hold_inst;
    logic [ID_W-1:0]       hold_id;
    logic [UW-1:0]         sel;
    logic [UW-1:0]         new_sel;
    logic [NUM_UNITS-1:0]  new_onehot;
    logic                  issue_take;
    logic                  issue_done;
    logic [UW-1:0]         rr_ptr;
    logic [UW-1:0]         grant;
    logic                  grant_valid;
    logic [DATA_WIDTH-1:0] grant_data;
    logic [ID_W-1:0]       grant_id;

    assign new_sel = instruction[UNIT_FIELD_LSB +: UW];

    // Issue FSM next state: IDLE pops when allowed, ISSUE waits for the unit.
    always_comb begin
        // NOTE: every variable gets a default first, so no path can infer a latch.
        state_d    = state;
        issue_take = 1'b0;
        issue_done = 1'b0;
        case (state)
            IDLE: begin
                if (instruction_valid && !halt && (outstanding < MAX_OUT)) begin
                    issue_take = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (unit_ready[sel]) begin
                    issue_done = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Issue FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (!rst) state <= IDLE;
        else      state <= state_d;
    end

    // One-hot decode of the unit field of the instruction being popped.
    always_comb begin
        new_onehot          = '0;
        new_onehot[new_sel] = 1'b1;
    end

    // Hold registers, pop pulse and per-unit valid; valid stays up until accepted.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: the hold registers are reset too, so a reset discards the held instruction.
        if (!rst) begin
            hold_inst        <= '0;
            hold_id          <= '0;
            sel              <= '0;
            instruction_next <= 1'b0;
            unit_valid       <= '0;
        end else begin
            instruction_next <= issue_take;
            if (issue_take) begin
                hold_inst  <= instruction;
                hold_id    <= instruction_id;
                sel        <= new_sel;
                unit_valid <= new_onehot;
            end else if (issue_done) begin
                unit_valid <= '0;
            end
        end
    end

    // Every unit sees the held instruction; only the selected one sees valid.
    assign unit_inst = {NUM_UNITS{hold_inst}};
    assign unit_id   = {NUM_UNITS{hold_id}};

    // Round-robin grant: first valid result at or after rr_ptr, with wrap.
    always_comb begin
        grant_valid = 1'b0;
        grant       = rr_ptr;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (!grant_valid && res_valid[rr_ptr + i[UW-1:0]]) begin
                grant_valid = 1'b1;
                grant       = rr_ptr + i[UW-1:0];
            end
        end
    end

    // Result mux and the combinational one-hot grant back to the units.
    always_comb begin
        grant_data = '0;
        grant_id   = '0;
        res_ready  = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (grant == k[UW-1:0]) begin
                grant_data = res_data[k*DATA_WIDTH +: DATA_WIDTH];
                grant_id   = res_id[k*ID_W +: ID_W];
            end
        end
        if (grant_valid) res_ready[grant] = 1'b1;
    end

    // Result write port: one strobe per transfer; data and pointer hold when idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data       <= '0;
            data_id    <= '0;
            data_valid <= 1'b0;
            rr_ptr     <= '0;
        end else begin
            data_valid <= grant_valid;
            if (grant_valid) begin
                data    <= grant_data;
                data_id <= grant_id;
                rr_ptr  <= grant + RR_ONE;
            end
        end
    end

    // Work in flight: issue adds one, a result removes one, never below zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outstanding <= '0;
        end else if (issue_done && !grant_valid) begin
            outstanding <= outstanding + CNT_ONE;
        end else if (grant_valid && !issue_done && (outstanding != '0)) begin
            outstanding <= outstanding - CNT_ONE;
        end
    end

    assign busy = (state != IDLE) || (outstanding != '0);

endmodule

// File: tb/tb_inst_dispatcher.sv
// Self-checking bench for inst_dispatcher: directed scenarios followed by
// random traffic, all compared against a transaction-level reference model.
module tb_inst_dispatcher;

    localparam int DW  = 64;
    localparam int NU  = 4;
    localparam int IW  = 4;
    localparam int LSB = 56;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [DW-1:0]     instruction;
    logic [IW-1:0]     instruction_id;
    logic              instruction_valid;
    logic              instruction_next;
    logic              halt;
    logic [NU*DW-1:0]  unit_inst;
    logic [NU*IW-1:0]  unit_id;
    logic [NU-1:0]     unit_valid;
    logic [NU-1:0]     unit_ready;
    logic [NU*DW-1:0]  res_data;
    logic [NU*IW-1:0]  res_id;
    logic [NU-1:0]     res_valid;
    logic [NU-1:0]     res_ready;
    logic [DW-1:0]     data;
    logic [IW-1:0]     data_id;
    logic              data_valid;
    logic [IW:0]       outstanding;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: one pending issue record, an integer work count,
    // a round-robin start index and the last forwarded result.
    bit            m_pending;
    bit            m_next;
    bit            m_dvalid;
    logic [DW-1:0] m_inst;
    logic [IW-1:0] m_id;
    int            m_unit;
    int            m_out;
    int            m_rr;
    logic [DW-1:0] m_data;
    logic [IW-1:0] m_did;

    inst_dispatcher dut (
        .clk               (clk),
        .rst               (rst),
        .instruction       (instruction),
        .instruction_id    (instruction_id),
        .instruction_valid (instruction_valid),
        .instruction_next  (instruction_next),
        .halt              (halt),
        .unit_inst         (unit_inst),
        .unit_id           (unit_id),
        .unit_valid        (unit_valid),
        .unit_ready        (unit_ready),
        .res_data          (res_data),
        .res_id            (res_id),
        .res_valid         (res_valid),
        .res_ready         (res_ready),
        .data              (data),
        .data_id           (data_id),
        .data_valid        (data_valid),
        .outstanding       (outstanding),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pending = 1'b0;
        m_next    = 1'b0;
        m_dvalid  = 1'b0;
        m_inst    = '0;
        m_id      = '0;
        m_unit    = 0;
        m_out     = 0;
        m_rr      = 0;
        m_data    = '0;
        m_did     = '0;
    endtask

    // Unit whose result is taken this cycle, or -1 when none is offered.
    function automatic int arb_grant();
        for (int i = 0; i < NU; i++) begin
            if (res_valid[(m_rr + i) % NU]) return (m_rr + i) % NU;
        end
        return -1;
    endfunction

    // Apply one clock edge of the rules to the model using the current inputs.
    task automatic model_advance();
        int g;
        bit tr;
        bit hs;
        bit pop;
        g   = arb_grant();
        tr  = (g >= 0);
        hs  = m_pending && unit_ready[m_unit];
        pop = !m_pending && instruction_valid && !halt && (m_out < 16);
        if (hs && !tr) m_out++;
        else if (tr && !hs && m_out > 0) m_out--;
        m_next = pop;
        if (pop) begin
            m_pending = 1'b1;
            m_inst    = instruction;
            m_id      = instruction_id;
            m_unit    = int'(instruction[LSB +: 2]);
        end else if (hs) begin
            m_pending = 1'b0;
        end
        m_dvalid = tr;
        if (tr) begin
            m_data = res_data[g*DW +: DW];
            m_did  = res_id[g*IW +: IW];
            m_rr   = (g + 1) % NU;
        end
    endtask

    // One cycle: inputs already set after a falling edge; check combinational
    // outputs, advance the model, check registered outputs after the edge.
    task automatic step();
        logic [NU-1:0] er;
        logic [NU-1:0] ev;
        int g;
        #1;
        g  = arb_grant();
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        check("res_ready", res_ready, er);
        check("busy", busy, m_pending || (m_out != 0));
        model_advance();
        @(posedge clk);
        #1;
        ev = '0;
        if (m_pending) ev[m_unit] = 1'b1;
        check("instruction_next", instruction_next, m_next);
        check("unit_valid", unit_valid, ev);
        check("outstanding", outstanding, m_out);
        check("data_valid", data_valid, m_dvalid);
        check("data", data, m_data);
        check("data_id", data_id, m_did);
        if (m_pending) begin
            check("unit_inst", unit_inst[m_unit*DW +: DW], m_inst);
            check("unit_id", unit_id[m_unit*IW +: IW], m_id);
        end
        @(negedge clk);
    endtask

    initial begin
        logic [3:0]  rr_exp [5];
        logic [31:0] r;
        int pops;
        int uv_cnt;
        int stall_pops;

        instruction       = '0;
        instruction_id    = '0;
        instruction_valid = 1'b0;
        halt              = 1'b0;
        unit_ready        = '0;
        res_valid         = '0;
        for (int k = 0; k < NU; k++) begin
            res_data[k*DW +: DW] = 64'hD00D_0000_0000_0000 + 64'(k);
            res_id[k*IW +: IW]   = 4'(k);
        end
        model_reset();

        // Reset state.
        @(negedge clk);
        check("rst_instruction_next", instruction_next, 1'b0);
        check("rst_unit_valid", unit_valid, 4'b0000);
        check("rst_data_valid", data_valid, 1'b0);
        check("rst_data", data, 64'h0);
        check("rst_data_id", data_id, 4'h0);
        check("rst_outstanding", outstanding, 5'd0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b1;
        step();

        // Basic issue to unit 2.
        instruction       = 64'h0200_0000_0000_00AB;
        instruction_id    = 4'd3;
        instruction_valid = 1'b1;
        unit_ready        = 4'b1111;
        step();
        check("basic_pop", instruction_next, 1'b1);
        check("basic_unit_valid", unit_valid, 4'b0100);
        check("basic_unit_inst", unit_inst[2*DW +: DW], 64'h0200_0000_0000_00AB);
        check("basic_unit_id", unit_id[2*IW +: IW], 4'd3);
        instruction_valid = 1'b0;
        step();
        check("basic_pop_end", instruction_next, 1'b0);
        check("basic_unit_valid_end", unit_valid, 4'b0000);
        check("basic_outstanding", outstanding, 5'd1);

        // Backpressure on unit 1 for five cycles.
        instruction       = 64'h0100_0000_0000_0011;
        instruction_id    = 4'd5;
        instruction_valid = 1'b1;
        unit_ready        = 4'b1101;
        pops   = 0;
        uv_cnt = 0;
        for (int c = 0; c < 7; c++) begin
            if (c == 6) begin
                unit_ready        = 4'b1111;
                instruction_valid = 1'b0;
            end
            step();
            if (instruction_next) pops++;
            if (unit_valid[1]) uv_cnt++;
        end
        check("bp_pops", pops, 1);
        check("bp_valid_cycles", uv_cnt, 6);
        check("bp_outstanding", outstanding, 5'd2);

        // Round-robin over four always-valid units.
        rr_exp = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
        res_valid = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("rr_onehot", $onehot(res_ready), 1'b1);
            #0;
            step();
            check("rr_data_id", data_id, rr_exp[c]);
            check("rr_data_valid", data_valid, 1'b1);
        end
        res_valid = '0;
        step();
        check("rr_drained", outstanding, 5'd0);

        // Throttle: sixteen issues without results, then one result frees a slot.
        instruction       = 64'h0300_0000_0000_0042;
        instruction_id    = 4'd7;
        instruction_valid = 1'b1;
        unit_ready        = 4'b1111;
        for (int c = 0; c < 32; c++) step();
        check("thr_full", outstanding, 5'd16);
        stall_pops = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (instruction_next) stall_pops++;
        end
        check("thr_stall_pops", stall_pops, 0);
        check("thr_busy", busy, 1'b1);
        res_valid = 4'b0001;
        step();
        check("thr_after_result", outstanding, 5'd15);
        res_valid = 4'b0000;
        step();
        check("thr_resume_pop", instruction_next, 1'b1);
        instruction_valid = 1'b0;
        step();
        check("thr_refull", outstanding, 5'd16);
        res_valid = 4'b1111;
        for (int c = 0; c < 18; c++) step();
        res_valid = '0;
        check("thr_drained", outstanding, 5'd0);

        // halt blocks issue from IDLE.
        halt              = 1'b1;
        instruction_valid = 1'b1;
        pops = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (instruction_next) pops++;
        end
        check("halt_pops", pops, 0);
        check("halt_busy", busy, 1'b0);
        halt = 1'b0;
        instruction_valid = 1'b0;

        // Issue handshake and result transfer in the same cycle at count 5.
        instruction_valid = 1'b1;
        for (int c = 0; c < 10; c++) step();
        instruction_valid = 1'b0;
        step();
        check("conc_start", outstanding, 5'd5);
        unit_ready        = 4'b0000;
        instruction_valid = 1'b1;
        step();
        instruction_valid = 1'b0;
        unit_ready        = 4'b1111;
        res_valid         = 4'b0100;
        step();
        check("conc_outstanding", outstanding, 5'd5);
        check("conc_data_valid", data_valid, 1'b1);
        check("conc_unit_valid", unit_valid, 4'b0000);
        res_valid = '0;

        // Asynchronous reset while an instruction sits in ISSUE.
        instruction       = 64'h0300_0000_0000_0077;
        instruction_valid = 1'b1;
        unit_ready        = 4'b0000;
        res_valid         = 4'b0001;
        step();
        check("ar_pre_pop", instruction_next, 1'b1);
        check("ar_pre_data_valid", data_valid, 1'b1);
        rst = 1'b0;
        #1;
        check("ar_unit_valid", unit_valid, 4'b0000);
        check("ar_instruction_next", instruction_next, 1'b0);
        check("ar_data_valid", data_valid, 1'b0);
        check("ar_outstanding", outstanding, 5'd0);
        check("ar_busy", busy, 1'b0);
        model_reset();
        instruction_valid = 1'b0;
        res_valid         = '0;
        @(negedge clk);
        rst = 1'b1;
        step();
        check("ar_no_repop", instruction_next, 1'b0);

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            instruction       = {$urandom(), $urandom()};
            r                 = $urandom();
            instruction_id    = r[23:20];
            instruction_valid = r[24] | r[25];
            unit_ready        = r[19:16];
            res_valid         = (r[27:26] == 2'b00) ? r[31:28] : 4'b0000;
            res_id            = r[15:0];
            res_data          = {$urandom(), $urandom(), $urandom(), $urandom(),
                                 $urandom(), $urandom(), $urandom(), $urandom()};
            halt              = ($urandom_range(9, 0) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
